// File: rtl/otter_pkg.sv
// Shared register-file write types and widths for the writeback path.
package otter_pkg;

    localparam int XLEN      = 32;
    localparam int RF_ADDR_W = 5;
    // Wide enough to hold an occupancy count up to 7 entries.
    localparam int CNT_W     = 3;

    typedef struct packed {
        logic [RF_ADDR_W-1:0] wa;
        logic [XLEN-1:0]      wd;
    } wb_req_t;

endpackage

// File: rtl/rf_wb_fifo.sv
// Small synchronous FIFO holding multi-cycle results waiting for the RF write port.
// The head entry is visible combinationally so it can be written in the same cycle it is popped.
module rf_wb_fifo
    import otter_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic    clk,
    input  logic    rst_n,
    input  logic    push_i,
    input  wb_req_t push_data_i,
    input  logic    pop_i,
    output wb_req_t head_o,
    output logic    full_o,
    output logic    empty_o
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    wb_req_t            mem_q [DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic               do_push;
    logic               do_pop;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign full_o  = (count_q == CNT_W'(DEPTH));
    assign empty_o = (count_q == '0);
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;
    assign head_o  = mem_q[rd_ptr_q];

    // Next pointer and occupancy values; simultaneous push and pop keep the count.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) wr_ptr_d = ptr_inc(wr_ptr_q);
        if (do_pop)  rd_ptr_d = ptr_inc(rd_ptr_q);
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // Pointer and count registers; reset drops every buffered entry.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Entry storage; no reset needed because the count gates what is visible.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= push_data_i;
    end

endmodule

// File: rtl/rf_wb_arbiter.sv
// Arbitrates the single register-file write port between the pipeline writeback
// (strict priority) and buffered multi-cycle results, and tracks registers whose
// multi-cycle result is still outstanding so decode can detect hazards.
module rf_wb_arbiter
    import otter_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                 CLK,
    input  logic                 RST_N,
    input  logic                 WB_EN,
    input  logic [RF_ADDR_W-1:0] WB_WA,
    input  logic [XLEN-1:0]      WB_WD,
    input  logic                 MD_VALID,
    input  logic [RF_ADDR_W-1:0] MD_WA,
    input  logic [XLEN-1:0]      MD_WD,
    output logic                 MD_READY,
    input  logic                 ISSUE_EN,
    input  logic [RF_ADDR_W-1:0] ISSUE_RD,
    input  logic [RF_ADDR_W-1:0] CHK_ADR1,
    input  logic [RF_ADDR_W-1:0] CHK_ADR2,
    input  logic [RF_ADDR_W-1:0] CHK_RD,
    output logic                 HAZARD,
    output logic                 RF_EN,
    output logic [RF_ADDR_W-1:0] RF_WA,
    output logic [XLEN-1:0]      RF_WD,
    output logic                 BUSY
);

    wb_req_t           push_data;
    wb_req_t           head;
    logic              fifo_full;
    logic              fifo_empty;
    logic              md_push;
    logic              md_pop;
    logic [XLEN-1:0]   pending_q, pending_d;

    assign push_data = '{wa: MD_WA, wd: MD_WD};
    assign MD_READY  = RST_N && !fifo_full;
    assign md_push   = MD_VALID && MD_READY;
    // The buffer only drains in cycles the pipeline is not writing.
    assign md_pop    = RST_N && !WB_EN && !fifo_empty;

    rf_wb_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk         (CLK),
        .rst_n       (RST_N),
        .push_i      (md_push),
        .push_data_i (push_data),
        .pop_i       (md_pop),
        .head_o      (head),
        .full_o      (fifo_full),
        .empty_o     (fifo_empty)
    );

    // Write-port mux: pipeline first, then buffer head, otherwise idle zeros.
    always_comb begin
        RF_EN = 1'b0;
        RF_WA = '0;
        RF_WD = '0;
        if (RST_N && WB_EN) begin
            RF_EN = 1'b1;
            RF_WA = WB_WA;
            RF_WD = WB_WD;
        end else if (md_pop) begin
            RF_EN = 1'b1;
            RF_WA = head.wa;
            RF_WD = head.wd;
        end
    end

    // Scoreboard update: clear on pop, then a new issue to the same rd wins; x0 never pends.
    always_comb begin
        pending_d = pending_q;
        if (md_pop) pending_d[head.wa] = 1'b0;
        if (ISSUE_EN && (ISSUE_RD != '0)) pending_d[ISSUE_RD] = 1'b1;
        pending_d[0] = 1'b0;
    end

    // Scoreboard register.
    always_ff @(posedge CLK) begin
        if (!RST_N) pending_q <= '0;
        else        pending_q <= pending_d;
    end

    // A register being written back this cycle is no longer a hazard: the RF
    // writes on the falling edge, so decode reads the fresh value.
    always_comb begin
        logic h1, h2, h3;
        h1 = pending_q[CHK_ADR1] && !(md_pop && (head.wa == CHK_ADR1));
        h2 = pending_q[CHK_ADR2] && !(md_pop && (head.wa == CHK_ADR2));
        h3 = pending_q[CHK_RD]   && !(md_pop && (head.wa == CHK_RD));
        HAZARD = RST_N && (h1 || h2 || h3);
    end

    assign BUSY = RST_N && ((|pending_q) || !fifo_empty);

endmodule

// File: doc/rf_wb_arbiter.md
RF_WB_ARBITER -- requirements
Module: rf_wb_arbiter

Interface
REQ-001 SHALL have parameter DEPTH, default 2; meaning: MD result buffer entries, legal 1..4.
REQ-002 SHALL have port CLK, in, 1; single clock; all state updates on posedge.
REQ-003 SHALL have port RST_N, in, 1; reset is synchronous and active-low.
REQ-004 SHALL have ports WB_EN, WB_WA, WB_WD; in; 1/5/32; pipeline writeback request, no backpressure.
REQ-005 SHALL have ports MD_VALID, MD_WA, MD_WD; in; 1/5/32; multi-cycle unit result, valid/ready.
REQ-006 SHALL have port MD_READY, out, 1; buffer can accept a result this cycle.
REQ-007 SHALL have ports ISSUE_EN, ISSUE_RD; in; 1/5; multi-cycle op issued, its rd becomes pending.
REQ-008 SHALL have ports CHK_ADR1, CHK_ADR2, CHK_RD; in; 5 each; decode-stage source and destination addresses.
REQ-009 SHALL have port HAZARD, out, 1; a checked register is pending.
REQ-010 SHALL have ports RF_EN, RF_WA, RF_WD; out; 1/5/32; single register-file write port.
REQ-011 SHALL have port BUSY, out, 1; any register pending or buffer non-empty.

Function
REQ-012 SHALL accept an MD result on a posedge where MD_VALID && MD_READY, pushing {MD_WA, MD_WD} into a FIFO.
REQ-013 SHALL drive MD_READY = (count < DEPTH) combinationally; no bypass, so MD write-back latency is at least 1 cycle after acceptance.
REQ-014 SHALL give WB strict priority: WB_EN=1 -> RF_EN=1, RF_WA=WB_WA, RF_WD=WB_WD, FIFO not popped.
REQ-015 SHALL, when WB_EN=0 and count>0, drive RF_EN=1 and RF_WA/RF_WD from the FIFO head, popping at the posedge.
REQ-016 SHALL drive RF_EN=0, RF_WA=0, RF_WD=0 when neither source writes.
REQ-017 SHALL allow push and pop in the same cycle; count is unchanged, including at count==DEPTH, where MD_READY stays 0 that cycle.
REQ-018 SHALL keep a 32-bit pending vector; bit 0 is never set.
REQ-019 SHALL set pending[ISSUE_RD] on a posedge with ISSUE_EN=1 and ISSUE_RD!=0.
REQ-020 SHALL clear pending[RF_WA] on a posedge with a FIFO pop.
REQ-021 SHALL let set win over clear when both target the same bit in one cycle.
REQ-022 SHALL compute HAZARD = any of pending[CHK_ADR1], pending[CHK_ADR2], pending[CHK_RD], with each term masked if that register is being popped this cycle; RF writes on negedge, so the value is readable the same cycle.
REQ-023 SHALL treat ISSUE_EN to an already-pending rd as upstream error; the bit stays set, and issue logic SHALL stall on HAZARD via CHK_RD.
REQ-024 SHALL treat WB_EN to a pending register as illegal upstream; it is not checked.
REQ-025 SHALL require MD_WA/MD_WD to be stable while MD_VALID && !MD_READY.

Reset
REQ-026 SHALL, on a posedge with RST_N=0: count=0, FIFO pointers=0, pending=0.
REQ-027 SHALL force MD_READY=0, RF_EN=0, HAZARD=0, BUSY=0 combinationally while RST_N=0.
REQ-028 SHALL discard in-flight FIFO entries and pending bits on reset mid-operation, with no RF write.

Structure
REQ-029 SHALL place XLEN=32, RF_ADDR_W=5, and typedef wb_req_t {wa, wd} in shared package otter_pkg.
REQ-030 SHALL implement the buffer as sub-module rf_wb_fifo (parameter DEPTH, sync, count-based full/empty); arbitration and scoreboard stay in rf_wb_arbiter.

Verification
REQ-031 SHALL test: WB_EN=1 WA=5 WD=0xAAAA5555 with FIFO empty -> RF_EN=1 WA=5 WD=0xAAAA5555 the same cycle.
REQ-032 SHALL test: ISSUE rd=7; CHK_ADR1=7 -> HAZARD=1; MD push WA=7 WD=0x1234 with WB idle -> next cycle RF write 7/0x1234, HAZARD=0 that cycle, pending[7]=0 after.
REQ-033 SHALL test: WB_EN held 3 cycles with 2 MD pushes -> MD_READY=0 after 2nd push; pops in order on cycles 4,5 once WB idles.
REQ-034 SHALL test: pop of rd=9 and ISSUE rd=9 in the same cycle -> pending[9]=1 afterward.
REQ-035 SHALL test: ISSUE rd=0, CHK_ADR1=0 -> HAZARD=0, BUSY=0.
REQ-036 SHALL test: RST_N=0 with 2 entries buffered and 3 pending -> next cycle count=0, BUSY=0, and no RF_EN until a new push.
